// File: rtl/snake_control.sv
// snake_control: snake body, movement, target detection, scoring and per-pixel colour
module snake_control #(
  parameter int MAX_LENGTH  = 32,
  parameter int INIT_LENGTH = 4,
  parameter int MOVE_TICKS  = 5000000,
  parameter int SCORE_WIN   = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [1:0]  DIRECTION,
  input  logic [7:0]  TARGET_ADDRH,
  input  logic [6:0]  TARGET_ADDRV,
  input  logic [7:0]  PIXEL_ADDRH,
  input  logic [6:0]  PIXEL_ADDRV,
  output logic [11:0] COLOUR_OUT,
  output logic        TARGET_REACHED,
  output logic [3:0]  SCORE,
  output logic [1:0]  STATE
);
  localparam int TW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam int LW = $clog2(MAX_LENGTH + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WIN = 2'b10, DEAD = 2'b11} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick;
  logic [1:0] dir, dir_nx;
  logic [7:0] seg_x [MAX_LENGTH];
  logic [6:0] seg_y [MAX_LENGTH];
  logic [7:0] head_x_nx;
  logic [6:0] head_y_nx;
  logic [LW-1:0] len;
  logic move_en, move_done, collide, hit, eat, head_px, body_px, tgt_px;
  logic [11:0] colour_nx;
  assign STATE = state;
  assign move_en = (state == PLAY) && (tick == TW'(MOVE_TICKS - 1));
  assign hit = (seg_x[0] == TARGET_ADDRH) && (seg_y[0] == TARGET_ADDRV);
  assign eat = (state == PLAY) && move_done && !collide && hit;
  assign dir_nx = ((DIRECTION[1] != dir[1]) && (DIRECTION[0] == dir[0])) ? dir : DIRECTION;
  assign head_x_nx = (dir_nx == 2'b01) ? ((seg_x[0] == 8'd159) ? 8'd0 : seg_x[0] + 8'd1) :
                     (dir_nx == 2'b11) ? ((seg_x[0] == 8'd0) ? 8'd159 : seg_x[0] - 8'd1) : seg_x[0];
  assign head_y_nx = (dir_nx == 2'b10) ? ((seg_y[0] == 7'd119) ? 7'd0 : seg_y[0] + 7'd1) :
                     (dir_nx == 2'b00) ? ((seg_y[0] == 7'd0) ? 7'd119 : seg_y[0] - 7'd1) : seg_y[0];
  // state register
  always_ff @(posedge CLK)
    state <= RESET ? IDLE : state_nx;
  // game flow: start, death on self-collision, win on the final eaten target
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && START) ? PLAY :
               (state == PLAY && move_done && collide) ? DEAD :
               (eat && SCORE == 4'(SCORE_WIN - 1)) ? WIN : state;
  end
  // head against the visible body, evaluated on the cycle after a move
  always_comb begin
    collide = 1'b0;
    head_px = (PIXEL_ADDRH == seg_x[0]) && (PIXEL_ADDRV == seg_y[0]);
    body_px = 1'b0;
    tgt_px = (PIXEL_ADDRH == TARGET_ADDRH) && (PIXEL_ADDRV == TARGET_ADDRV);
    for (int i = 1; i < MAX_LENGTH; i++) begin
      if (i < int'(len) && seg_x[i] == seg_x[0] && seg_y[i] == seg_y[0]) collide = 1'b1;
      if (i < int'(len) && seg_x[i] == PIXEL_ADDRH && seg_y[i] == PIXEL_ADDRV) body_px = 1'b1;
    end
    colour_nx = (state == IDLE) ? 12'h000 : (state == WIN) ? 12'h0F0 : (state == DEAD) ? 12'hF00 :
                head_px ? 12'hFF0 : body_px ? 12'h0F0 : tgt_px ? 12'hF00 : 12'h00F;
  end
  // step timer and latched heading; the heading only changes when the snake moves
  always_ff @(posedge CLK) begin
    tick <= RESET ? '0 : (state != PLAY) ? tick : move_en ? '0 : tick + 1'b1;
    dir <= RESET ? 2'b01 : move_en ? dir_nx : dir;
    move_done <= RESET ? 1'b0 : move_en;
  end
  // body shift register: every segment follows the one ahead, head steps forward
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        seg_x[i] <= 8'(20 - i);
        seg_y[i] <= 7'd60;
      end
    end else if (move_en) begin
      for (int i = 1; i < MAX_LENGTH; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
      seg_x[0] <= head_x_nx;
      seg_y[0] <= head_y_nx;
    end
  end
  // eating: one-cycle pulse, score and length grow with saturation
  always_ff @(posedge CLK) begin
    TARGET_REACHED <= RESET ? 1'b0 : eat;
    SCORE <= RESET ? 4'd0 : (eat && SCORE != 4'(SCORE_WIN)) ? SCORE + 4'd1 : SCORE;
    len <= RESET ? LW'(INIT_LENGTH) : (eat && len != LW'(MAX_LENGTH)) ? len + 1'b1 : len;
  end
  // registered pixel colour, one cycle behind the pixel address
  always_ff @(posedge CLK)
    COLOUR_OUT <= RESET ? 12'h000 : colour_nx;
endmodule
